// File: rtl/snitch_dma_req_arbiter.sv
// rtl/snitch_dma_req_arbiter.sv - round-robin DMA descriptor arbiter with in-order completion routing
//
// Collects transfer descriptors from NrReq requesters, grants one per cycle
// in round-robin order, queues them towards a single DMA backend and routes
// the backend's in-order completion pulses back to the owning requester.
//
// snitch_dma_req_arbiter_fifo ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, data_i     write side (push ignored when full unless popping)
//   pop_i, data_o      read side, data_o is the current head
//   empty_o, full_o    occupancy flags
//
// snitch_dma_req_arbiter ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_valid_i / req_ready_o      per-requester descriptor handshake
//   req_src_i, req_dst_i           packed per-requester addresses
//   req_len_i                      packed per-requester lengths (bytes)
//   be_valid_o / be_ready_i        descriptor handshake to the backend
//   be_src_o, be_dst_o, be_len_o   head descriptor
//   be_done_i                      backend completion pulse (issue order)
//   done_o                         one-cycle completion pulse per requester
//   busy_o                         at least one transfer outstanding
//   err_o                          sticky: completion with nothing outstanding

module snitch_dma_req_arbiter_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves in the same cycle;
  // the write slot then coincides with the slot just read out.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        if (wr_ptr_q == PtrW'(Depth - 1)) begin
          wr_ptr_q <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_q + PtrW'(1);
        end
      end
      if (pop_ok) begin
        if (rd_ptr_q == PtrW'(Depth - 1)) begin
          rd_ptr_q <= '0;
        end else begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

module snitch_dma_req_arbiter #(
  parameter int unsigned NrReq          = 9,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned LenWidth       = 32,
  parameter int unsigned ReqFifoDepth   = 3,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NrReq-1:0]              req_valid_i,
  output logic [NrReq-1:0]              req_ready_o,
  input  logic [NrReq*AddrWidth-1:0]    req_src_i,
  input  logic [NrReq*AddrWidth-1:0]    req_dst_i,
  input  logic [NrReq*LenWidth-1:0]     req_len_i,
  output logic                          be_valid_o,
  input  logic                          be_ready_i,
  output logic [AddrWidth-1:0]          be_src_o,
  output logic [AddrWidth-1:0]          be_dst_o,
  output logic [LenWidth-1:0]           be_len_o,
  input  logic                          be_done_i,
  output logic [NrReq-1:0]              done_o,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int unsigned IdxW  = (NrReq > 1) ? $clog2(NrReq) : 1;
  localparam int unsigned DescW = 2 * AddrWidth + LenWidth;

  logic [IdxW-1:0]  rr_q;
  logic [IdxW-1:0]  winner;
  logic             any_valid;
  logic             grant;
  logic             accept_ok;
  int unsigned      scan_idx;

  logic [DescW-1:0] push_desc;
  logic [DescW-1:0] head_desc;
  logic             req_empty;
  logic             req_full;

  logic [IdxW-1:0]  own_head;
  logic             own_empty;
  logic             own_full;
  logic             own_pop;

  logic [NrReq-1:0] done_next;
  logic [NrReq-1:0] done_q;
  logic             err_q;

  // Admission looks only at current occupancy, so a pop in this cycle does
  // not open a slot until the next one.
  assign accept_ok = ~req_full & ~own_full;

  // Round-robin scan starting at rr_q, wrapping past NrReq-1 back to 0.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    scan_idx  = 0;
    for (int i = 0; i < NrReq; i++) begin
      scan_idx = int'(rr_q) + i;
      if (scan_idx >= NrReq) begin
        scan_idx = scan_idx - NrReq;
      end
      if (!any_valid && req_valid_i[scan_idx]) begin
        any_valid = 1'b1;
        winner    = IdxW'(scan_idx);
      end
    end
  end

  // rst_ni gates the grant so that no requester sees ready during reset.
  assign grant = rst_ni & accept_ok & any_valid;

  always_comb begin
    req_ready_o = '0;
    push_desc   = '0;
    for (int i = 0; i < NrReq; i++) begin
      if (IdxW'(i) == winner) begin
        req_ready_o[i] = grant;
        push_desc      = {req_src_i[i*AddrWidth +: AddrWidth],
                          req_dst_i[i*AddrWidth +: AddrWidth],
                          req_len_i[i*LenWidth  +: LenWidth]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (grant) begin
      if (winner == IdxW'(NrReq - 1)) begin
        rr_q <= '0;
      end else begin
        rr_q <= winner + IdxW'(1);
      end
    end
  end

  snitch_dma_req_arbiter_fifo #(
    .Width (DescW),
    .Depth (ReqFifoDepth)
  ) i_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .data_i  (push_desc),
    .pop_i   (be_valid_o & be_ready_i),
    .data_o  (head_desc),
    .empty_o (req_empty),
    .full_o  (req_full)
  );

  // Owner indices in issue order; the backend completes in the same order.
  snitch_dma_req_arbiter_fifo #(
    .Width (IdxW),
    .Depth (MaxOutstanding)
  ) i_own_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .data_i  (winner),
    .pop_i   (own_pop),
    .data_o  (own_head),
    .empty_o (own_empty),
    .full_o  (own_full)
  );

  assign be_valid_o = ~req_empty;
  assign be_src_o   = head_desc[DescW-1 -: AddrWidth];
  assign be_dst_o   = head_desc[LenWidth +: AddrWidth];
  assign be_len_o   = head_desc[LenWidth-1:0];

  assign own_pop = be_done_i & ~own_empty;

  always_comb begin
    done_next = '0;
    for (int i = 0; i < NrReq; i++) begin
      if (IdxW'(i) == own_head) begin
        done_next[i] = own_pop;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done_next;
      if (be_done_i && own_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign done_o = done_q;
  assign err_o  = err_q;
  assign busy_o = ~own_empty;

endmodule

// File: tb/tb_snitch_dma_req_arbiter.sv
// tb/tb_snitch_dma_req_arbiter.sv - self-checking bench for snitch_dma_req_arbiter
//
// Per-cycle vectors {inputs, expected outputs}; descriptors expected on be_*
// are pushed to a scoreboard queue when a grant is expected and compared
// against the head of the queue whenever the backend interface is valid.

module tb_snitch_dma_req_arbiter;

  localparam int N  = 9;
  localparam int AW = 32;
  localparam int LW = 32;
  localparam int DW = 2 * AW + LW;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_ready_o;
  logic [N*AW-1:0] req_src_i = '0;
  logic [N*AW-1:0] req_dst_i = '0;
  logic [N*LW-1:0] req_len_i = '0;
  logic            be_valid_o;
  logic            be_ready_i = 1'b0;
  logic [AW-1:0]   be_src_o;
  logic [AW-1:0]   be_dst_o;
  logic [LW-1:0]   be_len_o;
  logic            be_done_i = 1'b0;
  logic [N-1:0]    done_o;
  logic            busy_o;
  logic            err_o;

  always #5 clk_i = ~clk_i;

  snitch_dma_req_arbiter dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_src_i   (req_src_i),
    .req_dst_i   (req_dst_i),
    .req_len_i   (req_len_i),
    .be_valid_o  (be_valid_o),
    .be_ready_i  (be_ready_i),
    .be_src_o    (be_src_o),
    .be_dst_o    (be_dst_o),
    .be_len_o    (be_len_o),
    .be_done_i   (be_done_i),
    .done_o      (done_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  typedef struct {
    logic [N-1:0] v;
    logic         br;
    logic         bd;
    logic [N-1:0] rdy;
    logic         bv;
    logic         busy;
    logic [N-1:0] done;
    logic         err;
  } vec_t;

  int              n_checks = 0;
  int              n_fail   = 0;
  int              seq [N];
  logic [DW-1:0]   sb_q [$];
  vec_t            tbl [17];

  function automatic vec_t mv(logic [N-1:0] v, logic br, logic bd, logic [N-1:0] rdy,
                              logic bv, logic busy, logic [N-1:0] done, logic err);
    vec_t r;
    r.v = v; r.br = br; r.bd = bd; r.rdy = rdy;
    r.bv = bv; r.busy = busy; r.done = done; r.err = err;
    return r;
  endfunction

  // Requester 0, sequence 0 carries a zero-length descriptor.
  function automatic logic [DW-1:0] mk_desc(int i, int s);
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    src = 32'h1000_0000 + 32'(i * 65536) + 32'(s);
    dst = 32'h8000_0000 + 32'(i * 4096) + 32'(s * 64);
    len = 32'(i * 16 + s);
    return {src, dst, len};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) begin
      d = mk_desc(i, seq[i]);
      req_src_i[i*AW +: AW] = d[DW-1 -: AW];
      req_dst_i[i*AW +: AW] = d[LW +: AW];
      req_len_i[i*LW +: LW] = d[LW-1:0];
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk_i);
    req_valid_i = v.v;
    be_ready_i  = v.br;
    be_done_i   = v.bd;
    drive_reqs();
    #1;
    check("req_ready", 128'(req_ready_o), 128'(v.rdy));
    check("be_valid",  128'(be_valid_o),  128'(v.bv));
    check("busy",      128'(busy_o),      128'(v.busy));
    check("done",      128'(done_o),      128'(v.done));
    check("err",       128'(err_o),       128'(v.err));
    if (be_valid_o) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL be_desc: got %0h expected none (t=%0t)", {be_src_o, be_dst_o, be_len_o}, $time);
      end else begin
        check("be_desc", 128'({be_src_o, be_dst_o, be_len_o}), 128'(sb_q[0]));
        if (be_ready_i) begin
          void'(sb_q.pop_front());
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (v.rdy[i]) begin
        sb_q.push_back(mk_desc(i, seq[i]));
        seq[i]++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni      = 1'b0;
    req_valid_i = '1;
    be_ready_i  = 1'b1;
    be_done_i   = 1'b1;
    #1;
    check("rst_ready", 128'(req_ready_o), 128'(0));
    check("rst_bv",    128'(be_valid_o),  128'(0));
    check("rst_busy",  128'(busy_o),      128'(0));
    check("rst_done",  128'(done_o),      128'(0));
    check("rst_err",   128'(err_o),       128'(0));
    @(negedge clk_i);
    req_valid_i = '0;
    be_ready_i  = 1'b0;
    be_done_i   = 1'b0;
    rst_ni      = 1'b1;
    sb_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) seq[i] = 0;

    // All requesters valid: 0,1,2,3 granted until 4 outstanding, then drain.
    tbl[0]  = mv(9'h1FF, 1, 0, 9'h001, 0, 0, 9'h000, 0);
    tbl[1]  = mv(9'h1FF, 1, 0, 9'h002, 1, 1, 9'h000, 0);
    tbl[2]  = mv(9'h1FF, 1, 0, 9'h004, 1, 1, 9'h000, 0);
    tbl[3]  = mv(9'h1FF, 1, 0, 9'h008, 1, 1, 9'h000, 0);
    tbl[4]  = mv(9'h1FF, 1, 0, 9'h000, 1, 1, 9'h000, 0);
    tbl[5]  = mv(9'h1FF, 1, 0, 9'h000, 0, 1, 9'h000, 0);
    tbl[6]  = mv(9'h000, 1, 1, 9'h000, 0, 1, 9'h000, 0);
    tbl[7]  = mv(9'h000, 1, 0, 9'h000, 0, 1, 9'h001, 0);
    tbl[8]  = mv(9'h100, 1, 0, 9'h100, 0, 1, 9'h000, 0);
    tbl[9]  = mv(9'h003, 1, 1, 9'h000, 1, 1, 9'h000, 0);
    tbl[10] = mv(9'h003, 1, 1, 9'h001, 0, 1, 9'h002, 0);
    tbl[11] = mv(9'h003, 1, 1, 9'h002, 1, 1, 9'h004, 0);
    tbl[12] = mv(9'h000, 1, 1, 9'h000, 1, 1, 9'h008, 0);
    tbl[13] = mv(9'h000, 1, 1, 9'h000, 0, 1, 9'h100, 0);
    tbl[14] = mv(9'h000, 1, 1, 9'h000, 0, 1, 9'h001, 0);
    tbl[15] = mv(9'h000, 1, 0, 9'h000, 0, 0, 9'h002, 0);
    tbl[16] = mv(9'h000, 0, 0, 9'h000, 0, 0, 9'h000, 0);

    do_reset();
    for (int k = 0; k < 17; k++) step(tbl[k]);

    // Backend stalled, core 3 fills the request FIFO; a pop while full does
    // not admit in the same cycle; order preserved while draining.
    do_reset();
    step(mv(9'h008, 0, 0, 9'h008, 0, 0, 9'h000, 0));
    step(mv(9'h008, 0, 0, 9'h008, 1, 1, 9'h000, 0));
    step(mv(9'h008, 0, 0, 9'h008, 1, 1, 9'h000, 0));
    step(mv(9'h008, 0, 0, 9'h000, 1, 1, 9'h000, 0));
    step(mv(9'h008, 1, 0, 9'h000, 1, 1, 9'h000, 0));
    step(mv(9'h008, 1, 0, 9'h008, 1, 1, 9'h000, 0));
    step(mv(9'h008, 1, 0, 9'h000, 1, 1, 9'h000, 0));
    step(mv(9'h008, 1, 0, 9'h000, 1, 1, 9'h000, 0));
    step(mv(9'h000, 1, 0, 9'h000, 0, 1, 9'h000, 0));

    // Cores 2 and 5, then two completions routed in issue order.
    do_reset();
    step(mv(9'h004, 0, 0, 9'h004, 0, 0, 9'h000, 0));
    step(mv(9'h020, 0, 0, 9'h020, 1, 1, 9'h000, 0));
    step(mv(9'h000, 1, 0, 9'h000, 1, 1, 9'h000, 0));
    step(mv(9'h000, 1, 0, 9'h000, 1, 1, 9'h000, 0));
    step(mv(9'h000, 0, 1, 9'h000, 0, 1, 9'h000, 0));
    step(mv(9'h000, 0, 1, 9'h000, 0, 1, 9'h004, 0));
    step(mv(9'h000, 0, 0, 9'h000, 0, 0, 9'h020, 0));
    step(mv(9'h000, 0, 0, 9'h000, 0, 0, 9'h000, 0));

    // Spurious completion: sticky error, no done, traffic still flows.
    do_reset();
    step(mv(9'h000, 0, 1, 9'h000, 0, 0, 9'h000, 0));
    step(mv(9'h000, 0, 0, 9'h000, 0, 0, 9'h000, 1));
    step(mv(9'h010, 1, 0, 9'h010, 0, 0, 9'h000, 1));
    step(mv(9'h000, 1, 0, 9'h000, 1, 1, 9'h000, 1));
    step(mv(9'h000, 1, 1, 9'h000, 0, 1, 9'h000, 1));
    step(mv(9'h000, 0, 0, 9'h000, 0, 0, 9'h010, 1));
    step(mv(9'h000, 0, 0, 9'h000, 0, 0, 9'h000, 1));

    // Reset mid-transfer with two outstanding: outputs drop at once and the
    // discarded transfers never complete.
    do_reset();
    step(mv(9'h001, 0, 0, 9'h001, 0, 0, 9'h000, 0));
    step(mv(9'h002, 0, 0, 9'h002, 1, 1, 9'h000, 0));
    step(mv(9'h000, 0, 0, 9'h000, 1, 1, 9'h000, 0));
    #2;
    rst_ni      = 1'b0;
    req_valid_i = '1;
    #1;
    check("async_ready", 128'(req_ready_o), 128'(0));
    check("async_bv",    128'(be_valid_o),  128'(0));
    check("async_busy",  128'(busy_o),      128'(0));
    check("async_done",  128'(done_o),      128'(0));
    check("async_err",   128'(err_o),       128'(0));
    @(negedge clk_i);
    req_valid_i = '0;
    rst_ni      = 1'b1;
    sb_q.delete();
    step(mv(9'h000, 0, 1, 9'h000, 0, 0, 9'h000, 0));
    step(mv(9'h000, 0, 0, 9'h000, 0, 0, 9'h000, 1));
    step(mv(9'h000, 0, 0, 9'h000, 0, 0, 9'h000, 1));

    check("sb_empty", 128'(sb_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
